// File: rtl/sram_rd_arbiter_pkg.sv
// sram_rd_arbiter_pkg: shared sizing constants, lock state encodings and index-width helper
package sram_rd_arbiter_pkg;
    localparam int SRA_PORT_NUM   = 16;
    localparam int SRA_ADDR_WIDTH = 11;
    localparam int SRA_DATA_WIDTH = 128;
    localparam int SRA_IDX_W      = $clog2(SRA_PORT_NUM);
    localparam logic [0:0] LOCK_IDLE   = 1'b0;
    localparam logic [0:0] LOCK_LOCKED = 1'b1;
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/sram_rd_arbiter_rr_picker.sv
// rr_picker: first requester at or after ptr (modulo N), as one-hot grant plus index
module rr_picker
    import sram_rd_arbiter_pkg::*;
#(
    parameter int N  = SRA_PORT_NUM,
    parameter int IW = idx_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          valid
);
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        // scan farthest offset first so the nearest requester overwrites
        for (int k = N - 1; k >= 0; k--) begin
            logic [IW-1:0] j;
            j = ptr + IW'(k);
            if (req[j]) begin
                idx   = j;
                valid = 1'b1;
            end
        end
        gnt = valid ? (N'(1) << idx) : '0;
    end
endmodule

// File: rtl/sram_rd_arbiter.sv
// sram_rd_arbiter: round-robin share of one SRAM read port; SRAM_RD_BURST_EN enables packet lock
module sram_rd_arbiter
    import sram_rd_arbiter_pkg::*;
#(
    parameter int PORT_NUM   = SRA_PORT_NUM,
    parameter int ADDR_WIDTH = SRA_ADDR_WIDTH,
    parameter int DATA_WIDTH = SRA_DATA_WIDTH
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [PORT_NUM-1:0]            rd_req,
    input  logic [PORT_NUM*ADDR_WIDTH-1:0] rd_addr,
    input  logic [PORT_NUM-1:0]            rd_last,
    output logic [PORT_NUM-1:0]            rd_ack,
    output logic                           sram_rd_en,
    output logic [ADDR_WIDTH-1:0]          sram_rd_addr,
    input  logic [DATA_WIDTH-1:0]          sram_rd_data,
    output logic [PORT_NUM-1:0]            rd_data_valid,
    output logic [DATA_WIDTH-1:0]          rd_data,
    output logic                           lock_busy
);
    localparam int IW = idx_w(PORT_NUM);
    logic [PORT_NUM-1:0]   cand_gnt, ack_vec;
    logic [IW-1:0]         cand_idx, ack_idx, rr_ptr_q, rr_ptr_d;
    logic                  cand_valid, ack_valid, adv;
    logic                  sram_rd_en_q, sram_rd_en_d;
    logic [ADDR_WIDTH-1:0] sram_rd_addr_q, sram_rd_addr_d;
    logic                  tag0_v_q, tag1_v_q;
    logic [IW-1:0]         tag0_idx_q, tag1_idx_q;
    logic [PORT_NUM-1:0]   rd_data_valid_q, rd_data_valid_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;

    rr_picker #(.N(PORT_NUM), .IW(IW)) u_picker (
        .req(rd_req), .ptr(rr_ptr_q), .gnt(cand_gnt), .idx(cand_idx), .valid(cand_valid)
    );

`ifdef SRAM_RD_BURST_EN
    logic [0:0]    lock_q, lock_d;
    logic [IW-1:0] lock_port_q, lock_port_d;
    logic          locked;
    always_comb begin
        locked      = lock_q == LOCK_LOCKED;
        ack_idx     = locked ? lock_port_q : cand_idx;
        ack_valid   = locked ? rd_req[lock_port_q] : cand_valid;
        ack_vec     = locked ? (rd_req & (PORT_NUM'(1) << lock_port_q)) : cand_gnt;
        adv         = ack_valid && rd_last[ack_idx];
        lock_d      = ack_valid ? (rd_last[ack_idx] ? LOCK_IDLE : LOCK_LOCKED) : lock_q;
        lock_port_d = ack_valid ? ack_idx : lock_port_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_q      <= LOCK_IDLE;
            lock_port_q <= '0;
        end else begin
            lock_q      <= lock_d;
            lock_port_q <= lock_port_d;
        end
    end
    assign lock_busy = locked;
`else
    logic unused_last;
    always_comb begin
        ack_idx   = cand_idx;
        ack_valid = cand_valid;
        ack_vec   = cand_gnt;
        adv       = cand_valid;
    end
    assign unused_last = ^rd_last;
    assign lock_busy   = LOCK_IDLE[0];
`endif

    always_comb begin
        rr_ptr_d        = adv ? ack_idx + IW'(1) : rr_ptr_q;
        sram_rd_en_d    = ack_valid;
        sram_rd_addr_d  = ack_valid ? rd_addr[ack_idx*ADDR_WIDTH +: ADDR_WIDTH] : sram_rd_addr_q;
        rd_data_valid_d = tag1_v_q ? (PORT_NUM'(1) << tag1_idx_q) : '0;
        rd_data_d       = tag1_v_q ? sram_rd_data : rd_data_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q        <= '0;
            sram_rd_en_q    <= 1'b0;
            sram_rd_addr_q  <= '0;
            tag0_v_q        <= 1'b0;
            tag0_idx_q      <= '0;
            tag1_v_q        <= 1'b0;
            tag1_idx_q      <= '0;
            rd_data_valid_q <= '0;
            rd_data_q       <= '0;
        end else begin
            rr_ptr_q        <= rr_ptr_d;
            sram_rd_en_q    <= sram_rd_en_d;
            sram_rd_addr_q  <= sram_rd_addr_d;
            tag0_v_q        <= ack_valid;
            tag0_idx_q      <= ack_idx;
            tag1_v_q        <= tag0_v_q;
            tag1_idx_q      <= tag0_idx_q;
            rd_data_valid_q <= rd_data_valid_d;
            rd_data_q       <= rd_data_d;
        end
    end

    assign rd_ack        = rst_n ? ack_vec : '0;
    assign sram_rd_en    = sram_rd_en_q;
    assign sram_rd_addr  = sram_rd_addr_q;
    assign rd_data_valid = rd_data_valid_q;
    assign rd_data       = rd_data_q;
endmodule

// File: tb/tb_sram_rd_arbiter.sv
// tb_sram_rd_arbiter: directed checks of ack order, pipeline timing, lock and reset; honours SRAM_RD_BURST_EN
module tb_sram_rd_arbiter;
    logic clk = 1'b0;
    logic rst_n;
    logic [15:0] rd_req, rd_last, rd_ack, rd_data_valid;
    logic [175:0] rd_addr;
    logic sram_rd_en, lock_busy;
    logic [10:0] sram_rd_addr;
    logic [127:0] sram_rd_data, rd_data;
    int total = 0;
    int bad = 0;

    sram_rd_arbiter dut (
        .clk(clk), .rst_n(rst_n), .rd_req(rd_req), .rd_addr(rd_addr), .rd_last(rd_last),
        .rd_ack(rd_ack), .sram_rd_en(sram_rd_en), .sram_rd_addr(sram_rd_addr),
        .sram_rd_data(sram_rd_data), .rd_data_valid(rd_data_valid), .rd_data(rd_data),
        .lock_busy(lock_busy)
    );

    always #5 clk = ~clk;

    task tick;
        @(posedge clk);
        #1;
    endtask

    task set_addr(input int p, input logic [10:0] a);
        rd_addr[p*11 +: 11] = a;
    endtask

    task do_reset;
        rst_n = 1'b0; rd_req = '0; rd_last = '0; rd_addr = '0; sram_rd_data = '0;
        tick; tick;
        rst_n = 1'b1;
    endtask

    task test_reset;
        rst_n = 1'b0; rd_req = 16'hFFFF; rd_last = '0; rd_addr = '0; sram_rd_data = '1;
        tick; #1;
        total++; if (rd_ack !== 16'h0) begin $display("FAIL reset_ack got=%h exp=0", rd_ack); bad++; end
        total++; if (sram_rd_en !== 1'b0 || sram_rd_addr !== 11'h0) begin
            $display("FAIL reset_sram got en=%b addr=%h exp en=0 addr=0", sram_rd_en, sram_rd_addr); bad++; end
        total++; if (rd_data_valid !== 16'h0 || rd_data !== 128'h0) begin
            $display("FAIL reset_data got v=%h d=%h exp 0", rd_data_valid, rd_data); bad++; end
        total++; if (lock_busy !== 1'b0) begin $display("FAIL reset_lock got=%b exp=0", lock_busy); bad++; end
    endtask

    task test_single;
        logic [127:0] d;
        d = 128'hCAFE_0001_2345_6789_ABCD_EF01_0203_0405;
        do_reset;
        rd_req = 16'h0001; set_addr(0, 11'h123); rd_last = 16'h0001; #1;
        total++; if (rd_ack !== 16'h0001) begin $display("FAIL single_ack got=%h exp=0001", rd_ack); bad++; end
        tick; rd_req = '0; #1;
        total++; if (sram_rd_en !== 1'b1 || sram_rd_addr !== 11'h123) begin
            $display("FAIL single_sram got en=%b addr=%h exp en=1 addr=123", sram_rd_en, sram_rd_addr); bad++; end
        tick; sram_rd_data = d; #1;
        total++; if (rd_data_valid !== 16'h0 || sram_rd_en !== 1'b0) begin
            $display("FAIL single_t2 got v=%h en=%b exp v=0 en=0", rd_data_valid, sram_rd_en); bad++; end
        tick; sram_rd_data = '0; #1;
        total++; if (rd_data_valid !== 16'h0001 || rd_data !== d) begin
            $display("FAIL single_t3 got v=%h d=%h exp v=0001 d=%h", rd_data_valid, rd_data, d); bad++; end
        tick; #1;
        total++; if (rd_data_valid !== 16'h0) begin $display("FAIL single_t4 got v=%h exp=0", rd_data_valid); bad++; end
    endtask

    task test_round_robin;
        do_reset;
        for (int p = 0; p < 16; p++) set_addr(p, 11'(p));
        rd_req = 16'hFFFF; rd_last = 16'hFFFF;
        for (int k = 0; k < 20; k++) begin
            sram_rd_data = 128'(1000 + k); #1;
            total++; if (rd_ack !== (16'(1) << (k % 16))) begin
                $display("FAIL rr_ack k=%0d got=%h exp=%h", k, rd_ack, 16'(1) << (k % 16)); bad++; end
            if (k >= 1) begin
                total++; if (sram_rd_en !== 1'b1 || sram_rd_addr !== 11'((k - 1) % 16)) begin
                    $display("FAIL rr_sram k=%0d got en=%b addr=%h exp en=1 addr=%h", k, sram_rd_en, sram_rd_addr, (k - 1) % 16); bad++; end
            end
            if (k >= 3) begin
                total++; if (rd_data_valid !== (16'(1) << ((k - 3) % 16)) || rd_data !== 128'(1000 + k - 1)) begin
                    $display("FAIL rr_data k=%0d got v=%h d=%0d exp v=%h d=%0d", k, rd_data_valid, rd_data,
                             16'(1) << ((k - 3) % 16), 1000 + k - 1); bad++; end
            end
            tick;
        end
        rd_req = '0;
    endtask

`ifdef SRAM_RD_BURST_EN
    task test_burst;
        logic [15:0] exp_ack [5] = '{16'h0008, 16'h0008, 16'h0008, 16'h0008, 16'h0020};
        logic        exp_busy [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        do_reset;
        for (int c = 0; c < 5; c++) begin
            rd_req = (c < 4) ? 16'h0028 : 16'h0020;
            rd_last = (c == 3) ? 16'h0028 : 16'h0020;
            set_addr(3, 11'(12'h30 + c)); #1;
            total++; if (rd_ack !== exp_ack[c] || lock_busy !== exp_busy[c]) begin
                $display("FAIL burst c=%0d got ack=%h busy=%b exp ack=%h busy=%b", c, rd_ack, lock_busy, exp_ack[c], exp_busy[c]); bad++; end
            if (c >= 1) begin
                total++; if (sram_rd_addr !== 11'(12'h30 + c - 1)) begin
                    $display("FAIL burst_addr c=%0d got=%h exp=%h", c, sram_rd_addr, 12'h30 + c - 1); bad++; end
            end
            tick;
        end
        rd_req = '0;
    endtask

    task test_stall;
        logic [15:0] prev;
        prev = '0;
        do_reset;
        for (int c = 0; c < 10; c++) begin
            logic [15:0] ea;
            logic eb;
            rd_req = (c < 2 || c == 7 || c == 8) ? 16'h0084 : 16'h0080;
            rd_last = (c == 8) ? 16'h0084 : 16'h0080;
            ea = (c < 2 || c == 7 || c == 8) ? 16'h0004 : (c == 9 ? 16'h0080 : 16'h0000);
            eb = (c >= 1 && c <= 8);
            #1;
            total++; if (rd_ack !== ea || lock_busy !== eb) begin
                $display("FAIL stall c=%0d got ack=%h busy=%b exp ack=%h busy=%b", c, rd_ack, lock_busy, ea, eb); bad++; end
            if (c >= 1) begin
                total++; if (sram_rd_en !== (prev != 0)) begin
                    $display("FAIL stall_en c=%0d got=%b exp=%b", c, sram_rd_en, prev != 0); bad++; end
            end
            prev = ea;
            tick;
        end
        rd_req = '0;
    endtask
`else
    task test_interleave;
        int n3, n5;
        n3 = 0; n5 = 0;
        do_reset;
        for (int c = 0; c < 10; c++) begin
            logic [15:0] ea;
            rd_req = {10'b0, n5 < 4, 1'b0, n3 < 4, 3'b0};
            rd_last = {10'b0, n5 == 3, 1'b0, n3 == 3, 3'b0};
            set_addr(3, 11'(12'h300 + n3)); set_addr(5, 11'(12'h500 + n5));
            ea = (c < 8) ? ((c % 2 == 0) ? 16'h0008 : 16'h0020) : 16'h0000;
            #1;
            total++; if (rd_ack !== ea || lock_busy !== 1'b0) begin
                $display("FAIL interleave c=%0d got ack=%h busy=%b exp ack=%h busy=0", c, rd_ack, lock_busy, ea); bad++; end
            if (ea[3]) n3++;
            if (ea[5]) n5++;
            tick;
        end
        rd_req = '0;
    endtask
`endif

    task test_reset_mid;
        do_reset;
        rd_req = 16'h0010; rd_last = 16'h0000; set_addr(4, 11'h044); #1;
        total++; if (rd_ack !== 16'h0010) begin $display("FAIL mid_ack got=%h exp=0010", rd_ack); bad++; end
        tick; rd_req = '0; rst_n = 1'b0; #1;
        total++; if (sram_rd_en !== 1'b0 || lock_busy !== 1'b0) begin
            $display("FAIL mid_async got en=%b busy=%b exp 0 0", sram_rd_en, lock_busy); bad++; end
        tick; rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            sram_rd_data = 128'hBAD0 + 128'(c); #1;
            total++; if (rd_data_valid !== 16'h0) begin
                $display("FAIL mid_valid c=%0d got=%h exp=0", c, rd_data_valid); bad++; end
            tick;
        end
        rd_req = 16'h8001; rd_last = 16'h8001; #1;
        total++; if (rd_ack !== 16'h0001 || lock_busy !== 1'b0) begin
            $display("FAIL mid_ptr got ack=%h busy=%b exp ack=0001 busy=0", rd_ack, lock_busy); bad++; end
        tick; rd_req = '0;
    endtask

    initial begin
        test_reset;
        test_single;
        test_round_robin;
`ifdef SRAM_RD_BURST_EN
        test_burst;
        test_stall;
`else
        test_interleave;
`endif
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sram_rd_arbiter.md
# sram_rd_arbiter

Round-robin arbiter sharing one SRAM read port among `PORT_NUM` output-port read engines. Each port's read engine presents page read requests. The arbiter accepts at most one request per cycle and drives the SRAM read strobe and address. It returns the read data, tagged one-hot to the requesting port, after a fixed pipeline delay. It sits between the per-port read dispatchers and the shared packet SRAM.

## Interface

Parameters:
- `PORT_NUM`, 16, number of requesting ports; must be a power of two, at most 32.
- `ADDR_WIDTH`, 11, SRAM page address width.
- `DATA_WIDTH`, 128, SRAM read data width.

Ports:
- `clk`  in  1  single clock domain.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `rd_req`  in  PORT_NUM  per-port request. Held with address until acked.
- `rd_addr`  in  PORT_NUM*ADDR_WIDTH  per-port page address; port i occupies slice [i*ADDR_WIDTH +: ADDR_WIDTH].
- `rd_last`  in  PORT_NUM  request is the last page of a packet.
- `rd_ack`  out  PORT_NUM  one-hot acceptance; combinational from registered grant state and `rd_req`.
- `sram_rd_en`  out  1  registered SRAM read strobe.
- `sram_rd_addr`  out  ADDR_WIDTH  registered SRAM address.
- `sram_rd_data`  in  DATA_WIDTH  SRAM data; valid one cycle after `sram_rd_en`.
- `rd_data_valid`  out  PORT_NUM  registered, one-hot destination of `rd_data`.
- `rd_data`  out  DATA_WIDTH  registered read data.
- `lock_busy`  out  1  registered; a packet lock is currently held.

## Operation

- Round-robin pointer `rr_ptr`, log2(PORT_NUM) bits, reset 0. Candidate = first i with `rd_req[i]`, scanning `rr_ptr`, `rr_ptr+1`, … modulo PORT_NUM. At most one `rd_ack` bit per cycle.
- Ack conditions:
  - Unlocked: ack the candidate.
  - Locked to port L: ack L only, and only if `rd_req[L]`.
  - Locked, `rd_req[L]` low: no ack. Lock is held and other ports stall. No timeout.
- On ack of port i:
  - Next cycle: `sram_rd_en`=1, `sram_rd_addr`=`rd_addr[i]`.
  - Port index i enters a 2-deep tag pipeline.
- Pointer update: see Configuration for when `rr_ptr` advances. When it advances, `rr_ptr` <= i+1, wrapping PORT_NUM-1 to 0.
- Lock FSM (burst mode only):
  - IDLE -> LOCKED(i) on ack with `rd_last[i]`=0.
  - LOCKED(i) -> IDLE on ack of i with `rd_last[i]`=1.
  - A single-page packet (ack with last=1 while IDLE) stays IDLE.
- Reset mid-operation: lock released, `rr_ptr`=0, tag pipeline cleared. In-flight SRAM data is discarded (no `rd_data_valid`).
- Reset values: `sram_rd_en`=0, `sram_rd_addr`=0, `rd_data_valid`=0, `rd_data`=0, `lock_busy`=0. `rd_ack`=0 while `rst_n` low.

## Timing

- Ack at cycle t -> `sram_rd_en` at t+1 -> `sram_rd_data` at t+2 -> `rd_data_valid`/`rd_data` at t+3.
- Throughput: one accepted page per cycle. Back-to-back acks to the same or different ports are allowed.
- A port may change `rd_addr`/`rd_last` in cycle t+1 after its ack at t. A new request from the same port can be acked at t+1.
- The new `rr_ptr` takes effect in the cycle after the ack.
- `lock_busy` rises the cycle after the first non-last ack. It falls the cycle after the last-page ack.

## Configuration

- `SRAM_RD_BURST_EN` defined:
  - Packet lock FSM is active.
  - `rr_ptr` advances only on acks with `rd_last`=1.
  - A packet's pages are read contiguously.
- `SRAM_RD_BURST_EN` undefined:
  - No lock FSM; `lock_busy` is tied 0 and `rd_last` is ignored.
  - `rr_ptr` advances on every ack, so pages of different ports interleave.

## Structure

- Shared package holds `PORT_NUM`, `ADDR_WIDTH`, `DATA_WIDTH`, the port index width constant, and lock state encodings (IDLE/LOCKED).
- One sub-module `rr_picker`: combinational request vector plus pointer -> one-hot grant and index, with valid. It is reusable by other shared-resource arbiters.

## Test plan

- Reset, then `rd_req`=0x0001, addr 0x123, last=1 at cycle t -> `rd_ack`=0x0001 at t; `sram_rd_en`/addr 0x123 at t+1; with `sram_rd_data`=D at t+2, `rd_data_valid`=0x0001 and `rd_data`=D at t+3.
- All 16 ports request single-page packets continuously -> acks in order 0,1,…,15,0 with one ack per cycle and no gaps.
- Burst mode: port 3 sends a 4-page packet (last on the 4th page) while port 5 requests constantly -> port 3 acked 4 consecutive cycles, then port 5. `lock_busy` is high for 3 cycles.
- Burst mode: port 2 drops `rd_req` mid-packet for 5 cycles while port 7 requests -> no acks for 5 cycles; port 2 resumes and completes before port 7 is served.
- Without the macro, ports 3 and 5 each send 4-page packets -> acks alternate 3,5,3,5,…
- Assert `rst_n` low one cycle after an ack -> `rd_data_valid` never pulses for that request, and after release `rr_ptr`=0 and the lock is released.
